// File: rtl/pergate_sum_seq.sv
// pergate_sum_seq
// Sums the three-point sumcheck contributions (evaluations at 0, 1, 2) of
// every gate in one prover layer, modulo the field prime. One modular adder
// per evaluation lane walks the gates one per cycle; the finished
// round-polynomial values are published on sum_out when the walk completes.

`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 65521
`endif

module pergate_sum_seq #(
    parameter int ngates = 8,
    parameter int ngbits = $clog2(ngates) + 1
) (
    input  logic                                  clk,
    input  logic                                  rstb,
    input  logic                                  en,
    input  logic [ngates-1:0]                     gates_ready,
    input  logic [ngates-1:0][2:0][`F_NBITS-1:0]  gate_in,
    output logic                                  ready_pulse,
    output logic                                  ready,
    output logic [2:0][`F_NBITS-1:0]              sum_out
);

    localparam int           NB  = `F_NBITS;
    localparam logic [NB:0]  W_Q = (NB + 1)'(`F_Q);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ngbits-1:0]       r_idx;
    logic [ngbits-1:0]       w_idx_next;
    logic [2:0][NB-1:0]      r_acc;
    logic [2:0][NB-1:0]      w_acc_next;
    logic [2:0][NB-1:0]      r_sum;
    logic [2:0][NB-1:0]      w_sum_next;
    logic                    r_en_dly;
    logic                    r_ready_dly;

    logic                    w_start;
    logic                    w_ready;
    logic                    w_last;
    logic [2:0][NB-1:0]      w_sel;
    logic [2:0][NB-1:0]      w_addmod;

    // A summation starts only on a fresh rising edge of en while every gate
    // has its contribution ready and we are idle; an edge seen with any gate
    // not ready is simply lost.
    assign w_start = en & ~r_en_dly & (&gates_ready) & (r_state == S_IDLE);

    // ready drops already in the start cycle so the layer FSM never sees a
    // stale "idle" while the start is being taken.
    assign w_ready     = (r_state == S_IDLE) & ~w_start;
    assign ready       = w_ready;
    assign ready_pulse = w_ready & ~r_ready_dly;
    assign sum_out     = r_sum;

    // The accumulation stops at the final gate; idx never wraps.
    assign w_last = (r_idx == ngbits'(ngates - 1));

    // Select the current gate's three contributions by index compare, which
    // keeps the index width independent of the gate-array width.
    always_comb begin
        w_sel = '0;
        for (int g = 0; g < ngates; g++) begin
            if (r_idx == ngbits'(g)) begin
                w_sel = gate_in[g];
            end
        end
    end

    // One single-step modular adder per evaluation lane. Both operands are
    // already reduced, so one conditional subtraction of the prime suffices.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [NB:0] w_s;
            assign w_s          = {1'b0, r_acc[gi]} + {1'b0, w_sel[gi]};
            assign w_addmod[gi] = (w_s >= W_Q) ? NB'(w_s - W_Q) : w_s[NB-1:0];
        end
    endgenerate

    // Next-state and next-datapath logic for the IDLE -> ACCUM -> DONE walk.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_acc_next   = r_acc;
        w_sum_next   = r_sum;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_acc_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_acc_next = w_addmod;
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_idx_next = r_idx + ngbits'(1);
                end
            end
            S_DONE: begin
                // sum_out is only touched here, so consumers can keep reading
                // the previous result for the whole accumulation.
                w_sum_next   = r_acc;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and gate index registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Per-lane accumulators and the published result.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_acc <= '0;
            r_sum <= '0;
        end else begin
            r_acc <= w_acc_next;
            r_sum <= w_sum_next;
        end
    end

    // Edge detectors for en and ready; both come out of reset high so a level
    // already present at release neither starts a summation nor pulses.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_en_dly    <= 1'b1;
            r_ready_dly <= 1'b1;
        end else begin
            r_en_dly    <= en;
            r_ready_dly <= w_ready;
        end
    end

endmodule

// File: tb/tb_pergate_sum_seq.sv
// Testbench for pergate_sum_seq: random and directed gate contributions
// checked against a plain modular-sum reference, plus trigger, latency,
// pulse and reset behaviour.

`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 65521
`endif

module tb_pergate_sum_seq;

    localparam int              NG = 4;
    localparam int              NB = `F_NBITS;
    localparam longint unsigned FQ = `F_Q;

    logic                        clk;
    logic                        rstb;
    logic                        en;
    logic [NG-1:0]               gates_ready;
    logic [NG-1:0][2:0][NB-1:0]  gate_in;
    logic                        ready_pulse;
    logic                        ready;
    logic [2:0][NB-1:0]          sum_out;

    int                          n_vec;
    int                          n_err;
    logic [2:0][NB-1:0]          model_sum;

    pergate_sum_seq #(.ngates(NG)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .en          (en),
        .gates_ready (gates_ready),
        .gate_in     (gate_in),
        .ready_pulse (ready_pulse),
        .ready       (ready),
        .sum_out     (sum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain sum over all gates reduced modulo the prime.
    function automatic logic [NB-1:0] model_lane(input int k);
        longint unsigned t;
        t = 0;
        for (int g = 0; g < NG; g++) t += longint'(gate_in[g][k]);
        return NB'(t % FQ);
    endfunction

    task automatic fill_random();
        for (int g = 0; g < NG; g++)
            for (int k = 0; k < 3; k++)
                gate_in[g][k] = NB'($urandom_range(int'(FQ - 1), 0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one summation from a rising en. toggles: number of en flips
    // during ACCUM. b2b: return in the pulse cycle so the caller can
    // restart immediately.
    task automatic do_sum(input string tag, input int toggles, input bit b2b);
        logic [2:0][NB-1:0] want;
        int lat;
        int pulses;
        for (int k = 0; k < 3; k++) want[k] = model_lane(k);
        lat    = -1;
        pulses = 0;
        en     = 1'b1;
        for (int c = 1; c <= NG + 6; c++) begin
            tick();
            if (ready_pulse) begin
                pulses++;
                if (lat < 0) lat = c;
            end
            if (c == 1) check_val({tag, ".busy"}, 64'(ready), 64'd0);
            if (c == 3) check_val({tag, ".hold"}, 64'(sum_out), 64'(model_sum));
            if (c >= 2 && c < 2 + toggles) en = ~en;
            if (b2b && lat > 0) break;
        end
        check_val({tag, ".latency"}, 64'(lat), 64'(NG + 2));
        check_val({tag, ".pulses"}, 64'(pulses), 64'd1);
        check_val({tag, ".ready"}, 64'(ready), 64'd1);
        for (int k = 0; k < 3; k++)
            check_val($sformatf("%s.sum%0d", tag, k), 64'(sum_out[k]), 64'(want[k]));
        model_sum = want;
        $display("sum %s: lat=%0d out={%0d,%0d,%0d} exp={%0d,%0d,%0d}", tag, lat,
                 sum_out[0], sum_out[1], sum_out[2], want[0], want[1], want[2]);
        if (!b2b) begin
            en = 1'b0;
            tick();
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        model_sum   = '0;
        rstb        = 1'b0;
        en          = 1'b1;
        gates_ready = '1;
        gate_in     = '0;

        // Reset with en held high: no start, no pulse after release.
        repeat (3) tick();
        rstb = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val("rst.ready", 64'(ready), 64'd1);
            check_val("rst.pulse", 64'(ready_pulse), 64'd0);
        end
        check_val("rst.sum", 64'(sum_out), 64'd0);
        en = 1'b0;
        tick();

        // Directed: gate_in[g][k] = g+k+1 -> {10,14,18}.
        for (int g = 0; g < NG; g++)
            for (int k = 0; k < 3; k++)
                gate_in[g][k] = NB'(g + k + 1);
        do_sum("ramp", 0, 1'b0);
        check_val("ramp.const0", 64'(sum_out[0]), 64'd10);
        check_val("ramp.const2", 64'(sum_out[2]), 64'd18);

        // Modular wrap: all F_Q-1.
        for (int g = 0; g < NG; g++)
            for (int k = 0; k < 3; k++)
                gate_in[g][k] = NB'(FQ - 1);
        do_sum("wrap", 0, 1'b0);
        check_val("wrap.const", 64'(sum_out[1]), 64'(FQ - 4));

        // Sum landing exactly on F_Q.
        gate_in = '0;
        for (int k = 0; k < 3; k++) begin
            gate_in[0][k] = NB'(FQ - 2);
            gate_in[1][k] = NB'(2);
        end
        do_sum("exact", 0, 1'b0);

        // en rising while a gate is not ready is lost.
        fill_random();
        gates_ready = 4'b1011;
        en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("notrdy.ready", 64'(ready), 64'd1);
        end
        gates_ready = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("held.ready", 64'(ready), 64'd1);
            check_val("held.pulse", 64'(ready_pulse), 64'd0);
        end
        en = 1'b0;
        tick();
        do_sum("retrig", 0, 1'b0);

        // en toggling during ACCUM, then immediate back-to-back.
        fill_random();
        do_sum("toggle", 3, 1'b1);
        fill_random();
        do_sum("b2b", 0, 1'b0);

        // Random sums.
        for (int r = 0; r < 6; r++) begin
            fill_random();
            do_sum($sformatf("rnd%0d", r), r % 4, 1'b0);
        end

        // Asynchronous reset in the second ACCUM cycle.
        fill_random();
        en = 1'b1;
        tick();
        tick();
        rstb = 1'b0;
        #1;
        check_val("arst.sum", 64'(sum_out), 64'd0);
        check_val("arst.ready", 64'(ready), 64'd1);
        check_val("arst.pulse", 64'(ready_pulse), 64'd0);
        model_sum = '0;
        tick();
        rstb = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val("arst.rel_pulse", 64'(ready_pulse), 64'd0);
            check_val("arst.rel_ready", 64'(ready), 64'd1);
        end
        en = 1'b0;
        tick();
        do_sum("after_rst", 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
